// File: rtl/nxm_pkg.sv
// Shared types and constants for the N x M word deserializer.
package nxm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } deser_state_t;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/nxm_word_deserializer_if.sv
// Word-in / frame-out handshake bundle for the word deserializer.
interface nxm_word_deserializer_if #(
   parameter int unsigned N = 4,
   parameter int unsigned M = 8
);
   localparam int unsigned LEN_W = $clog2(N + 1);

   logic [M-1:0]     DIN;
   logic             IN_VALID;
   logic             IN_READY;
   logic             DIR;
   logic             FLUSH;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [N*M-1:0]   DOUT_F;
   logic [LEN_W-1:0] OUT_LEN;

   modport master (
      output DIN, IN_VALID, DIR, FLUSH, OUT_READY,
      input  IN_READY, OUT_VALID, DOUT_F, OUT_LEN
   );

   modport slave (
      input  DIN, IN_VALID, DIR, FLUSH, OUT_READY,
      output IN_READY, OUT_VALID, DOUT_F, OUT_LEN
   );
endinterface

// File: rtl/nxm_word_deserializer.sv
// Assembles N M-bit words into an N*M-bit frame, LSB- or MSB-word first,
// with zero-padded flush of partial frames and valid/ready frame output.
module nxm_word_deserializer
   import nxm_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned M = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   nxm_word_deserializer_if.slave  bus
);
   localparam int unsigned NM    = N * M;
   localparam int unsigned LEN_W = $clog2(N + 1);

   deser_state_t     state, state_nx;
   logic [NM-1:0]    shreg, shreg_nx, base, padded;
   logic [LEN_W-1:0] cnt, cnt_nx, len, len_nx, cnt_after, pad_cnt;
   logic             dir_q, dir_nx, dir_eff;
   logic             out_valid, in_ready, accept;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and datapath next values
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      len_nx   = len;
      dir_nx   = dir_q;
      shreg_nx = shreg;

      // A new frame takes its order from DIR; a frame in progress keeps dir_q
      dir_eff = (state == FILL) ? dir_q : bus.DIR;
      base    = shreg;
      if (accept) begin
         if (dir_eff == DIR_MSB_FIRST) base = {shreg[NM-M-1:0], bus.DIN};
         else                          base = {bus.DIN, shreg[NM-1:M]};
      end

      cnt_after = cnt + LEN_W'(accept);
      pad_cnt   = LEN_W'(N) - cnt_after;
      padded    = base;
      for (int k = 1; k < int'(N); k++) begin
         if (pad_cnt == LEN_W'(k)) begin
            if (dir_q == DIR_MSB_FIRST) padded = base << (k * M);
            else                        padded = base >> (k * M);
         end
      end

      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = FILL;
               cnt_nx   = LEN_W'(1);
               dir_nx   = bus.DIR;
               shreg_nx = base;
            end
         end
         FILL: begin
            if (cnt_after == LEN_W'(N)) begin
               state_nx = FULL;
               len_nx   = LEN_W'(N);
               cnt_nx   = '0;
               shreg_nx = base;
            end else if (bus.FLUSH) begin
               state_nx = FULL;
               len_nx   = cnt_after;
               cnt_nx   = '0;
               shreg_nx = padded;
            end else begin
               cnt_nx   = cnt_after;
               shreg_nx = base;
            end
         end
         FULL: begin
            if (bus.OUT_READY) begin
               if (accept) begin
                  state_nx = FILL;
                  cnt_nx   = LEN_W'(1);
                  dir_nx   = bus.DIR;
                  shreg_nx = base;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: input readiness depends on state and OUT_READY only
   always_comb begin
      in_ready = (state != FULL) || bus.OUT_READY;
      accept   = bus.IN_VALID && in_ready;
   end

   // Frame register, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         cnt       <= '0;
         len       <= '0;
         dir_q     <= DIR_LSB_FIRST;
         out_valid <= 1'b0;
      end else begin
         shreg     <= shreg_nx;
         cnt       <= cnt_nx;
         len       <= len_nx;
         dir_q     <= dir_nx;
         out_valid <= (state_nx == FULL);
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = out_valid;
   assign bus.DOUT_F    = shreg;
   assign bus.OUT_LEN   = len;

endmodule

// File: doc/nxm_word_deserializer.md
# nxm_word_deserializer

Serial-to-parallel counterpart of the N×M word shift register: it accepts one M-bit word per handshake and assembles N words into an N*M-bit frame. It sits on the receive side of the word-serial link and presents completed frames on a valid/ready output port. It supports LSB-word-first and MSB-word-first ordering and a flush that zero-pads partial frames.

## Interface
Parameters:
- `N`, 4: words per frame (≥2).
- `M`, 8: bits per word (≥1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `DIN`  in  M  incoming word.
- `IN_VALID`  in  1  `DIN` is valid.
- `IN_READY`  out  1  block can accept `DIN` this cycle (combinational).
- `DIR`  in  1  word order: 0 = LSB word first, 1 = MSB word first; sampled with the first word of each frame.
- `FLUSH`  in  1  close the current partial frame with zero padding.
- `OUT_VALID`  out  1  `DOUT_F` holds a complete frame.
- `OUT_READY`  in  1  downstream consumes the frame.
- `DOUT_F`  out  N*M  assembled frame (shift register contents).
- `OUT_LEN`  out  $clog2(N+1)  number of real, non-pad words in the frame (1..N).

## Operation
- States: IDLE (no words held), FILL (1..N-1 words held), FULL (frame presented).
- Accept = `IN_VALID && IN_READY`.
- `IN_READY` = (state != FULL) || `OUT_READY`.
- Shift on accept:
  - `dir_q` = 0: reg <= {DIN, reg[N*M-1:M]}. The first word ends in bits [M-1:0].
  - `dir_q` = 1: reg <= {reg[N*M-M-1:0], DIN}. The first word ends in the top word.
- `dir_q` loads from `DIR` on an accept in IDLE, or on an accept in FULL that coincides with a frame handoff. It is held for the rest of the frame; `DIR` changes mid-frame are ignored.
- Word counter `cnt` holds 0..N-1.
- Transitions:
  - IDLE, accept → FILL, `cnt`=1.
  - FILL, accept with `cnt`=N-1 → FULL, `OUT_LEN`=N, `cnt`=0.
  - FILL, accept otherwise → `cnt`+1.
  - FULL, `OUT_READY` without accept → IDLE.
  - FULL, `OUT_READY` with accept → FILL, `cnt`=1, new frame begins with that word.
  - FULL, `OUT_READY` low → hold. Register, `OUT_LEN` and `OUT_VALID` are all stable.
- FLUSH, in FILL only:
  - The frame is completed in one cycle by shifting in (N-`cnt`) zero words in the current direction.
  - State → FULL, `OUT_LEN`=`cnt`, `cnt`=0.
  - FLUSH in IDLE or FULL is ignored.
- FLUSH with accept in the same cycle: the word is accepted first, then the flush applies with `OUT_LEN`=`cnt`+1.
  - If that word completes the frame, the flush is a no-op (`OUT_LEN`=N).
- `DOUT_F` is the raw register in every state; it is only meaningful while `OUT_VALID`=1.

## Timing
- Reset values: register = 0, `cnt`=0, state = IDLE, `dir_q`=0, `OUT_VALID`=0, `OUT_LEN`=0, `DOUT_F`=0, `IN_READY`=1 (IDLE).
- No accept or flush takes effect while `rst` is high.
- Latency: `OUT_VALID` rises the cycle after the N-th accept, or the cycle after FLUSH.
- Throughput: one word per cycle sustained. There is no bubble between frames when `OUT_READY`=1.
- `OUT_VALID` stays asserted until the `OUT_READY` handshake. `DOUT_F` does not change while `OUT_VALID`=1 and `OUT_READY`=0.
- `IN_READY` has a combinational path from `OUT_READY` only.
- `rst` asserted mid-frame discards all partial data immediately. The first post-reset accept starts a new frame in IDLE.

## Structure
- Shared package `nxm_pkg`:
  - `deser_state_t` enum {IDLE, FILL, FULL}.
  - Direction constants `DIR_LSB_FIRST`=1'b0 and `DIR_MSB_FIRST`=1'b1.
- Single module, no sub-module.
- The zero-pad shift by (N-`cnt`)*M is an N-way mux per direction, generated by a loop.

## Test plan
All scenarios use N=4, M=8.
- DIR=0, words 0x11, 0x22, 0x33, 0x44 back-to-back → `DOUT_F`=0x44332211, `OUT_LEN`=4. `OUT_VALID` rises the cycle after the 4th accept.
- DIR=1, same words → `DOUT_F`=0x11223344, `OUT_LEN`=4.
- Flush after a partial frame:
  - DIR=0, 0xAA, 0xBB, then FLUSH → `DOUT_F`=0x0000BBAA, `OUT_LEN`=2.
  - DIR=1, same words and FLUSH → 0xAABB0000, `OUT_LEN`=2.
  - FLUSH in IDLE → no change.
- Backpressure:
  - Complete a frame, hold `OUT_READY`=0 for 3 cycles → `IN_READY`=0 and `DOUT_F` stable.
  - Then `OUT_READY`=1 with `IN_VALID`=1, DIN=0x55 → frame consumed, state FILL, `cnt`=1, no word lost.
- Simultaneous events:
  - FLUSH with the 3rd accept (0xCC) → `OUT_LEN`=3, DIR=0 `DOUT_F`=0x00CCBBAA.
  - FLUSH with the 4th accept → `OUT_LEN`=4.
- Reset mid-frame: assert `rst` asynchronously after 2 words → `OUT_VALID`=0 and `DOUT_F`=0 immediately. A subsequent 4-word frame assembles correctly with `DIR` re-sampled.
